// File: rtl/led_pwm_driver_if.sv
// -----------------------------------------------------------------------------
// led_pwm_driver_if
//   CPU I/O bus between the processor's memory-mapped LED register and the
//   led_pwm_driver brightness stage.
//
//   writeEnable  master->slave  write strobe, one cycle per write
//   readEnable   master->slave  read strobe
//   channelSel   master->slave  duty register index 0..3
//   writeData    master->slave  duty value to write
//   readData     slave->master  staged duty of channelSel, registered
// -----------------------------------------------------------------------------
interface led_pwm_driver_if;
    logic       writeEnable;
    logic       readEnable;
    logic [1:0] channelSel;
    logic [7:0] writeData;
    logic [7:0] readData;

    modport master (
        output writeEnable,
        output readEnable,
        output channelSel,
        output writeData,
        input  readData
    );

    modport slave (
        input  writeEnable,
        input  readEnable,
        input  channelSel,
        input  writeData,
        output readData
    );
endinterface

// File: rtl/led_pwm_driver.sv
// -----------------------------------------------------------------------------
// led_pwm_driver
//   Brightness stage for four board LEDs. The CPU writes four 8-bit duty values
//   over the I/O bus. One shared, prescaled 8-bit counter generates the PWM
//   pattern for all four pins. Duties are double-buffered: bus writes land in a
//   staged copy, and the staged copy moves to the active copy only when the
//   counter wraps. That way brightness changes only at a period boundary.
//
//   Parameters
//     PRESCALE    clk cycles per PWM counter tick (>=1)
//     ACTIVE_LOW  1: pin low = LED on, 0: pin high = LED on
//
//   Ports
//     clk          system clock, rising edge
//     resetN       asynchronous active-low reset
//     bus          CPU bus (slave side), readData registered
//     periodStart  one-clk pulse in the first cycle with pwmCount == 0
//     led1..led4   registered PWM pins for channels 0..3
// -----------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int unsigned PRESCALE   = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetN,
    led_pwm_driver_if.slave        bus,
    output logic                   periodStart,
    output logic                   led1,
    output logic                   led2,
    output logic                   led3,
    output logic                   led4
);

    // A prescaler of 1 still needs a 1-bit register so the widths stay legal.
    localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic           LED_OFF = ACTIVE_LOW;

    logic [PS_W-1:0] prescale_q, prescale_d;
    logic [7:0]      pwm_count_q, pwm_count_d;
    logic [7:0]      read_data_q, read_data_d;
    logic            period_start_q, period_start_d;
    logic            tick;
    logic            wrap;

    logic [7:0]      staged_vec [4];
    logic [3:0]      led_vec;

    // Shared prescaler and PWM counter.
    always_comb begin
        tick           = (prescale_q == PS_LAST);
        wrap           = tick && (pwm_count_q == 8'hFF);
        prescale_d     = tick ? '0 : prescale_q + PS_W'(1);
        pwm_count_d    = tick ? pwm_count_q + 8'd1 : pwm_count_q;
        period_start_d = wrap;
    end

    // Reads see the staged copy as it was before this edge. A read and a write
    // to the same channel in one cycle therefore return the old value.
    always_comb begin
        read_data_d = read_data_q;
        if (bus.readEnable) begin
            read_data_d = staged_vec[bus.channelSel];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prescale_q     <= '0;
            pwm_count_q    <= 8'd0;
            read_data_q    <= 8'd0;
            period_start_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            pwm_count_q    <= pwm_count_d;
            read_data_q    <= read_data_d;
            period_start_q <= period_start_d;
        end
    end

    // Per-channel duty double buffer and pin register.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [7:0] staged_q, staged_d;
        logic [7:0] active_q, active_d;
        logic       led_q, led_d;
        logic       on;

        always_comb begin
            staged_d = staged_q;
            if (bus.writeEnable && (bus.channelSel == 2'(gi))) begin
                staged_d = bus.writeData;
            end
            // The transfer takes the pre-edge staged value, so a write in the
            // wrap cycle waits for the following boundary.
            active_d = wrap ? staged_q : active_q;
            // 8'hFF is special-cased so full duty means constantly on.
            on       = (active_q == 8'hFF) || (pwm_count_q < active_q);
            led_d    = on ^ ACTIVE_LOW;
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                staged_q <= 8'd0;
                active_q <= 8'd0;
                led_q    <= LED_OFF;
            end else begin
                staged_q <= staged_d;
                active_q <= active_d;
                led_q    <= led_d;
            end
        end

        assign staged_vec[gi] = staged_q;
        assign led_vec[gi]    = led_q;
    end

    assign bus.readData = read_data_q;
    assign periodStart  = period_start_q;
    assign led1         = led_vec[0];
    assign led2         = led_vec[1];
    assign led3         = led_vec[2];
    assign led4         = led_vec[3];

endmodule
